solution_serializer: RTL and testbench



---
 rtl/solution_serializer.sv | 157 +++++++++++++++
 tb/tb_solution_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/solution_serializer.sv
// Streams a latched solver bitmap to uart_tx as a header byte {m,n} followed by
// row-packed bytes, handshaking each byte with transmit_done.
module solution_serializer #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11
) (
    input  logic                             clk_50mhz,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0]     solution,
    input  logic [$clog2(MAX_ROWS)-1:0]      m,
    input  logic [$clog2(MAX_COLS)-1:0]      n,
    input  logic                             transmit_done,
    output logic                             send,
    output logic [7:0]                       byte_out,
    output logic                             busy,
    output logic                             done
);
    localparam int TOTAL = MAX_ROWS * MAX_COLS;
    localparam int R_W   = $clog2(MAX_ROWS + 1);
    localparam int C_W   = $clog2(MAX_COLS + 1);
    localparam int J_W   = $clog2((MAX_COLS + 7) / 8 + 1);
    localparam int IDX_W = $clog2(TOTAL + 8);
    localparam int PAD_W = 2 ** IDX_W;

    typedef enum logic [2:0] {IDLE, HDR, WAIT, NEXT, ROW, FIN} state_t;

    state_t           state_reg, state_next;
    logic [TOTAL-1:0] sol_reg, sol_next;
    logic [R_W-1:0]   m_reg, m_next;
    logic [C_W-1:0]   n_reg, n_next;
    logic [R_W-1:0]   r_reg, r_next;
    logic [J_W-1:0]   j_reg, j_next;
    logic             send_reg, send_next;
    logic [7:0]       byte_reg, byte_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [R_W-1:0]   m_sat;
    logic [C_W-1:0]   n_sat;
    logic [PAD_W-1:0] sol_pad;
    logic [IDX_W-1:0] row_base;
    logic [IDX_W-1:0] chunk_base;
    logic [C_W+3:0]   n_ext;
    logic [J_W-1:0]   chunks;
    logic [7:0]       row_byte;
    logic             rows_left;
    logic             last_chunk;

    assign m_sat = (32'(m) > 32'(MAX_ROWS)) ? R_W'(MAX_ROWS) : R_W'(m);
    assign n_sat = (32'(n) > 32'(MAX_COLS)) ? C_W'(MAX_COLS) : C_W'(n);

    // Zero padding keeps the cell index in range for the last partial chunk.
    assign sol_pad    = {{(PAD_W - TOTAL){1'b0}}, sol_reg};
    assign row_base   = IDX_W'(r_reg) * IDX_W'(MAX_COLS);
    assign chunk_base = IDX_W'({j_reg, 3'b000});
    assign n_ext      = (C_W + 4)'(n_reg) + (C_W + 4)'(7);
    assign chunks     = J_W'(n_ext >> 3);
    assign rows_left  = (r_reg < m_reg) && (chunks != '0);
    assign last_chunk = (j_reg == (chunks - J_W'(1)));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            logic [IDX_W-1:0] col;
            assign col          = chunk_base + IDX_W'(gi);
            assign row_byte[gi] = (col < IDX_W'(n_reg)) && sol_pad[row_base + col];
        end
    endgenerate

    // Outputs are registered, so HDR and NEXT load the pulse that is visible
    // during the following WAIT/ROW/FIN cycle.
    always_comb begin
        state_next = state_reg;
        sol_next   = sol_reg;
        m_next     = m_reg;
        n_next     = n_reg;
        r_next     = r_reg;
        j_next     = j_reg;
        send_next  = 1'b0;
        byte_next  = byte_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_in) begin
                    sol_next   = solution;
                    m_next     = m_sat;
                    n_next     = n_sat;
                    r_next     = '0;
                    j_next     = '0;
                    state_next = HDR;
                end
            end
            HDR: begin
                send_next  = 1'b1;
                byte_next  = {4'(m_reg), 4'(n_reg)};
                state_next = WAIT;
            end
            WAIT: begin
                if (transmit_done) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (rows_left) begin
                    send_next = 1'b1;
                    byte_next = row_byte;
                    if (last_chunk) begin
                        j_next = '0;
                        r_next = r_reg + R_W'(1);
                    end else begin
                        j_next = j_reg + J_W'(1);
                    end
                    state_next = ROW;
                end else begin
                    done_next  = 1'b1;
                    state_next = FIN;
                end
            end
            ROW:     state_next = WAIT;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_reg <= IDLE;
            sol_reg   <= '0;
            m_reg     <= '0;
            n_reg     <= '0;
            r_reg     <= '0;
            j_reg     <= '0;
            send_reg  <= 1'b0;
            byte_reg  <= 8'h00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sol_reg   <= sol_next;
            m_reg     <= m_next;
            n_reg     <= n_next;
            r_reg     <= r_next;
            j_reg     <= j_next;
            send_reg  <= send_next;
            byte_reg  <= byte_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign send     = send_reg;
    assign byte_out = byte_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
endmodule

// File: tb/tb_solution_serializer.sv
// Bench for solution_serializer: a uart_tx responder model plus a byte-list
// reference model built directly from the board rules.
module tb_solution_serializer;
    localparam int MR  = 11;
    localparam int MC  = 11;
    localparam int TOT = MR * MC;

    logic           clk_50mhz = 1'b0;
    logic           rst = 1'b1;
    logic           valid_in = 1'b0;
    logic [TOT-1:0] solution = '0;
    logic [3:0]     m = 4'd0;
    logic [3:0]     n = 4'd0;
    logic           transmit_done = 1'b0;
    logic           send;
    logic [7:0]     byte_out;
    logic           busy;
    logic           done;

    always #10 clk_50mhz = ~clk_50mhz;

    solution_serializer #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
        .clk_50mhz     (clk_50mhz),
        .rst           (rst),
        .valid_in      (valid_in),
        .solution      (solution),
        .m             (m),
        .n             (n),
        .transmit_done (transmit_done),
        .send          (send),
        .byte_out      (byte_out),
        .busy          (busy),
        .done          (done)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         uart_cnt = 0;
    int         uart_lat = 20;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         send_cyc_q[$];
    int         td_cyc_q[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         stab_err = 0;
    logic [7:0] prev_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [TOT-1:0] rand_sol();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[TOT-1:0];
    endfunction

    // One clock: sample outputs at negedge, then drive the next inputs.
    task automatic step();
        @(negedge clk_50mhz);
        cyc++;
        valid_in      = 1'b0;
        transmit_done = 1'b0;
        solution      = rand_sol();
        m             = 4'($urandom);
        n             = 4'($urandom);
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                transmit_done = 1'b1;
                td_cyc_q.push_back(cyc);
            end
        end
        if (send) begin
            got_q.push_back(byte_out);
            send_cyc_q.push_back(cyc);
            uart_cnt = uart_lat;
        end else if (byte_out !== prev_byte) begin
            stab_err++;
        end
        prev_byte = byte_out;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic build_exp(input int mi, input int ni, input logic [TOT-1:0] sol);
        int mm;
        int nn;
        int v;
        mm = (mi > MR) ? MR : mi;
        nn = (ni > MC) ? MC : ni;
        exp_q.delete();
        exp_q.push_back(8'((mm % 16) * 16 + (nn % 16)));
        for (int r = 0; r < mm; r++) begin
            for (int j = 0; j < (nn + 7) / 8; j++) begin
                v = 0;
                for (int k = 0; k < 8; k++) begin
                    if ((8 * j + k) < nn && sol[r * MC + 8 * j + k]) v += (1 << k);
                end
                exp_q.push_back(8'(v));
            end
        end
    endtask

    task automatic run_xfer(input string tag, input int mi, input int ni,
                            input logic [TOT-1:0] sol, input int lat, input bit interfere);
        int t0;
        int guard;
        int busy_low;
        int nb;
        bit injected;
        got_q.delete();
        send_cyc_q.delete();
        td_cyc_q.delete();
        done_cnt = 0;
        stab_err = 0;
        busy_low = 0;
        guard    = 0;
        injected = 1'b0;
        uart_lat = lat;
        build_exp(mi, ni, sol);
        step();
        valid_in = 1'b1;
        m        = 4'(mi);
        n        = 4'(ni);
        solution = sol;
        t0       = cyc;
        step();
        while (done_cnt == 0 && guard < 3000) begin
            if (!busy) busy_low++;
            step();
            guard++;
            if (interfere && !injected && got_q.size() == 3) begin
                valid_in = 1'b1;
                m        = 4'd2;
                n        = 4'd2;
                solution = '1;
                injected = 1'b1;
            end
        end
        chk({tag, ".timeout"}, 32'(guard >= 3000), 32'd0);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd1);
        step();
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        repeat (4) step();
        chk({tag, ".nbytes"}, got_q.size(), exp_q.size());
        nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++) chk($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
        if (send_cyc_q.size() > 0) chk({tag, ".hdr_lat"}, send_cyc_q[0] - t0, 32'd2);
        for (int i = 1; i < send_cyc_q.size() && i <= td_cyc_q.size(); i++)
            chk($sformatf("%s.send_lat%0d", tag, i), send_cyc_q[i] - td_cyc_q[i-1], 32'd2);
        if (td_cyc_q.size() > 0) chk({tag, ".done_lat"}, done_cyc - td_cyc_q[td_cyc_q.size()-1], 32'd2);
        chk({tag, ".done_cnt"}, done_cnt, 32'd1);
        chk({tag, ".busy_low"}, busy_low, 32'd0);
        chk({tag, ".stable"}, stab_err, 32'd0);
        $display("xfer %-12s m=%0d n=%0d lat=%0d bytes=%0d expected=%0d", tag, mi, ni, lat,
                 got_q.size(), exp_q.size());
    endtask

    initial begin
        logic [TOT-1:0] s;
        int t_rst;
        repeat (3) step();
        chk("rst.send", 32'(send), 32'd0);
        chk("rst.byte", 32'(byte_out), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        rst = 1'b0;
        prev_byte = byte_out;
        step();

        s = '0;
        s[0] = 1'b1; s[2] = 1'b1; s[12] = 1'b1; s[22] = 1'b1; s[23] = 1'b1; s[24] = 1'b1;
        run_xfer("b3x3", 3, 3, s, 20, 1'b0);
        run_xfer("full11", 11, 11, '1, 20, 1'b0);
        s = '0;
        s[120] = 1'b1;
        run_xfer("corner", 11, 11, s, 20, 1'b0);
        run_xfer("m0n5", 0, 5, rand_sol(), 20, 1'b0);
        run_xfer("interfere", 11, 11, rand_sol(), 20, 1'b1);

        got_q.delete();
        step();
        transmit_done = 1'b1;
        repeat (6) step();
        chk("idle_td.sends", got_q.size(), 32'd0);
        chk("idle_td.busy", 32'(busy), 32'd0);

        got_q.delete();
        uart_lat = 20;
        step();
        valid_in = 1'b1;
        m        = 4'd11;
        n        = 4'd11;
        solution = '1;
        repeat (40) step();
        rst      = 1'b1;
        uart_cnt = 0;
        t_rst    = cyc;
        step();
        chk("abort.send", 32'(send), 32'd0);
        chk("abort.byte", 32'(byte_out), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.cycle", cyc - t_rst, 32'd1);
        rst = 1'b0;
        repeat (3) step();
        run_xfer("after_rst", 1, 8, TOT'(8'h5A), 20, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("rand%0d", i), $urandom_range(0, 15), $urandom_range(0, 15),
                     rand_sol(), $urandom_range(1, 25), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
